// File: rtl/ex_stage.sv
// ex_stage: OpenMIPS execute stage. Single-cycle logic/arith/compare ops,
// a 32-iteration restoring divider for DIV/DIVU, and the EX/MEM register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no divide in flight; single-cycle ops pass straight through
// DIV_ON   | restoring shift-subtract, one quotient bit per cycle
// DIV_ZERO | divisor was zero; load the fixed all-ones/dividend result
// DIV_END  | result ready; written to HI/LO when downstream is not held
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'h24;
  localparam logic [7:0] EXE_OR_OP   = 8'h25;
  localparam logic [7:0] EXE_XOR_OP  = 8'h26;
  localparam logic [7:0] EXE_NOR_OP  = 8'h27;
  localparam logic [7:0] EXE_ADDU_OP = 8'h21;
  localparam logic [7:0] EXE_SUBU_OP = 8'h23;
  localparam logic [7:0] EXE_SLT_OP  = 8'h2A;
  localparam logic [7:0] EXE_SLTU_OP = 8'h2B;
  localparam logic [7:0] EXE_DIV_OP  = 8'h1A;
  localparam logic [7:0] EXE_DIVU_OP = 8'h1B;

  localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DIV_ON   = 2'd1;
  localparam logic [1:0] S_DIV_END  = 2'd2;
  localparam logic [1:0] S_DIV_ZERO = 2'd3;

  localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] wdata_q;
  logic        whilo_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_div;
  logic        is_signed;
  logic [31:0] dvnd_abs;
  logic [31:0] dvsr_abs;
  logic [32:0] rem_shift;
  logic        sub_ok;
  logic [31:0] rem_step;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic [31:0] logic_res;
  logic [31:0] arith_res;
  logic [31:0] alu_res;

  assign is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_signed = (aluop_i == EXE_DIV_OP);
  assign dvnd_abs  = (is_signed && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign dvsr_abs  = (is_signed && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  // The partial remainder can exceed 32 bits after the shift, so compare in 33.
  assign rem_shift = {rem_q, quo_q[31]};
  assign sub_ok    = (rem_shift >= {1'b0, dvsr_q});
  assign rem_step  = sub_ok ? 32'(rem_shift - {1'b0, dvsr_q}) : rem_shift[31:0];

  assign quo_fin = neg_quo_q ? (32'd0 - quo_q) : quo_q;
  assign rem_fin = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  assign stallreq_o = rst && !flush_i &&
                      (((state_q == S_IDLE) && is_div) ||
                       (state_q == S_DIV_ON) || (state_q == S_DIV_ZERO));

  // Single-cycle ALU result, selected by result class
  always_comb begin
    logic_res = 32'd0;
    arith_res = 32'd0;
    alu_res   = 32'd0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'd0;
    endcase
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {31'd0, (reg1_i < reg2_i)};
      default:     arith_res = 32'd0;
    endcase
    case (alusel_i)
      EXE_RES_LOGIC:      alu_res = logic_res;
      EXE_RES_ARITHMETIC: alu_res = arith_res;
      default:            alu_res = 32'd0;
    endcase
  end

  // Divider FSM and datapath next-state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div) begin
            if (reg2_i == 32'd0) begin
              state_d = S_DIV_ZERO;
            end else begin
              quo_d     = dvnd_abs;
              rem_d     = 32'd0;
              dvsr_d    = dvsr_abs;
              cnt_d     = 5'd0;
              neg_quo_d = is_signed && (reg1_i[31] ^ reg2_i[31]);
              neg_rem_d = is_signed && reg1_i[31];
              state_d   = S_DIV_ON;
            end
          end
        end
        S_DIV_ON: begin
          rem_d = rem_step;
          quo_d = {quo_q[30:0], sub_ok};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DIV_END;
          end
        end
        S_DIV_ZERO: begin
          // Divide-by-zero result is reported raw, without sign fix-up.
          quo_d     = 32'hFFFF_FFFF;
          rem_d     = reg1_i;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
          state_d   = S_DIV_END;
        end
        S_DIV_END: begin
          if (!stall_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM and divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // EX/MEM register: bubble on flush or self-stall, hold on downstream stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'd0;
      whilo_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (flush_i || (stallreq_o && !stall_i)) begin
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'd0;
      whilo_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (!stall_i) begin
      if (state_q == S_DIV_END) begin
        wd_q    <= wd_i;
        wreg_q  <= 1'b0;
        wdata_q <= 32'd0;
        whilo_q <= 1'b1;
        hi_q    <= rem_fin;
        lo_q    <= quo_fin;
      end else begin
        wd_q    <= wd_i;
        wreg_q  <= wreg_i;
        wdata_q <= alu_res;
        whilo_q <= 1'b0;
        hi_q    <= 32'd0;
        lo_q    <= 32'd0;
      end
    end
  end

  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;
  assign whilo_o = whilo_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed and randomized checks against a
// behavioural reference computed from the instruction semantics.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, stall_i, flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (sel == 3'b001) begin
      if (op == 8'h24) return a & b;
      if (op == 8'h25) return a | b;
      if (op == 8'h26) return a ^ b;
      if (op == 8'h27) return ~(a | b);
      return 32'd0;
    end
    if (sel == 3'b100) begin
      if (op == 8'h21) return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      if (op == 8'h23) return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      if (op == 8'h2A) return (sa < sb) ? 32'd1 : 32'd0;
      if (op == 8'h2B) return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      return 32'd0;
    end
    return 32'd0;
  endfunction

  task automatic model_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == 8'h1B) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(8'h1B, 3'b100, 32'd9, 32'd3, 5'd1, 1'b1);
    #12;
    n_tests++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h, want all 0",
               wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o);
    end
    n_tests++;
    if (stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stallreq: got %b want 0", stallreq_o);
    end
    drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed_alu;
    tick;
    drive(8'h25, 3'b001, 32'h0000_1100, 32'h0000_0011, 5'd3, 1'b1);
    tick;
    n_tests++;
    if (wdata_o !== 32'h0000_1111 || wd_o !== 5'd3 || wreg_o !== 1'b1 || whilo_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ori: got wdata=%h wd=%0d wreg=%b whilo=%b, want 00001111 3 1 0",
               wdata_o, wd_o, wreg_o, whilo_o);
    end
    drive(8'h2A, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    tick;
    n_tests++;
    if (wdata_o !== 32'd1) begin
      n_fail++;
      $display("FAIL slt: got %h want 00000001", wdata_o);
    end
    drive(8'h2B, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    tick;
    n_tests++;
    if (wdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL sltu: got %h want 00000000", wdata_o);
    end
    drive(8'h21, 3'b100, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1);
    tick;
    n_tests++;
    if (wdata_o !== 32'd1) begin
      n_fail++;
      $display("FAIL addu_wrap: got %h want 00000001", wdata_o);
    end
  endtask

  task automatic test_random_alu;
    logic [7:0]  ops [11];
    logic [2:0]  sels [4];
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b, exp;
    logic [4:0]  wd;
    logic        wr;
    ops  = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h21, 8'h23, 8'h2A, 8'h2B, 8'h00, 8'h20, 8'h2C};
    sels = '{3'b000, 3'b001, 3'b100, 3'b111};
    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 10)];
      sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : sels[$urandom_range(1, 2)];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      wd  = 5'($urandom);
      wr  = 1'($urandom);
      drive(op, sel, a, b, wd, wr);
      exp = model_alu(op, sel, a, b);
      tick;
      n_tests++;
      if (wdata_o !== exp || wd_o !== wd || wreg_o !== wr || whilo_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_alu op=%h sel=%0d a=%h b=%h: got wdata=%h wd=%0d wreg=%b whilo=%b, want %h %0d %b 0",
                 op, sel, a, b, wdata_o, wd_o, wreg_o, whilo_o, exp, wd, wr);
      end
    end
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int end_hold);
    logic [31:0] eq, er;
    int cnt, bad, exp_cnt;
    model_div(op, a, b, eq, er);
    exp_cnt = (b == 32'd0) ? 2 : 33;
    drive(op, 3'b100, a, b, 5'd9, 1'b0);
    #1;
    cnt = 0; bad = 0;
    while (stallreq_o === 1'b1 && cnt < 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (wreg_o !== 1'b0 || whilo_o !== 1'b0) bad++;
    end
    n_tests++;
    if (cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL div_stall_len op=%h a=%h b=%h: got %0d cycles want %0d", op, a, b, cnt, exp_cnt);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL div_bubble op=%h: got %0d non-bubble cycles want 0", op, bad);
    end
    if (end_hold > 0) begin
      stall_i = 1'b1;
      repeat (end_hold) tick;
      n_tests++;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
        n_fail++;
        $display("FAIL div_end_hold: got whilo=%b stallreq=%b want 0 0", whilo_o, stallreq_o);
      end
      stall_i = 1'b0;
    end
    tick;
    drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    n_tests++;
    if (lo_o !== eq || hi_o !== er || whilo_o !== 1'b1 || wreg_o !== 1'b0) begin
      n_fail++;
      $display("FAIL div_result op=%h a=%h b=%h: got lo=%h hi=%h whilo=%b wreg=%b, want lo=%h hi=%h 1 0",
               op, a, b, lo_o, hi_o, whilo_o, wreg_o, eq, er);
    end
  endtask

  task automatic test_div;
    logic [7:0]  op;
    logic [31:0] a, b;
    do_div(8'h1A, 32'hFFFF_FFF9, 32'd2, 0);
    do_div(8'h1B, 32'd100, 32'd0, 0);
    do_div(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 8'h1A : 8'h1B;
      a  = $urandom;
      case ($urandom_range(0, 2))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd3;
      do_div(op, a, b, (i == 2) ? 3 : 0);
    end
  endtask

  task automatic test_flush;
    drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd2, 1'b0);
    tick;
    repeat (10) tick;
    flush_i = 1'b1;
    #1;
    n_tests++;
    if (stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stallreq: got %b want 0", stallreq_o);
    end
    tick;
    flush_i = 1'b0;
    drive(8'h25, 3'b001, 32'h0000_1100, 32'h0000_0011, 5'd7, 1'b1);
    #1;
    n_tests++;
    if (stallreq_o !== 1'b0 || wreg_o !== 1'b0 || whilo_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bubble: got stallreq=%b wreg=%b whilo=%b want 0 0 0",
               stallreq_o, wreg_o, whilo_o);
    end
    tick;
    n_tests++;
    if (wdata_o !== 32'h0000_1111 || wd_o !== 5'd7 || wreg_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next_ori: got wdata=%h wd=%0d wreg=%b want 00001111 7 1",
               wdata_o, wd_o, wreg_o);
    end
  endtask

  task automatic test_async_reset;
    drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd2, 1'b0);
    tick;
    repeat (5) tick;
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== '0 || stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stallreq=%b want all 0",
               wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
    end
    drive(8'h00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_div(8'h1B, 32'd9, 32'd3, 0);
  endtask

  task automatic test_stall_hold;
    drive(8'h26, 3'b001, 32'hF0F0_0000, 32'h0FF0_00FF, 5'd11, 1'b1);
    tick;
    stall_i = 1'b1;
    drive(8'h24, 3'b001, 32'hFFFF_0000, 32'h1234_5678, 5'd12, 1'b1);
    tick;
    tick;
    n_tests++;
    if (wdata_o !== 32'hFF00_00FF || wd_o !== 5'd11) begin
      n_fail++;
      $display("FAIL stall_hold: got wdata=%h wd=%0d want ff0000ff 11", wdata_o, wd_o);
    end
    stall_i = 1'b0;
    tick;
    n_tests++;
    if (wdata_o !== 32'h1234_0000 || wd_o !== 5'd12) begin
      n_fail++;
      $display("FAIL stall_release: got wdata=%h wd=%0d want 12340000 12", wdata_o, wd_o);
    end
  endtask

  initial begin
    test_reset;
    test_directed_alu;
    test_random_alu;
    test_div;
    test_flush;
    test_async_reset;
    test_stall_hold;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
